lc3b_mem_responder: RTL and testbench
=====================================

LC3B_MEM_RESPONDER -- requirements
Module: lc3b_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 16-bit words stored, power of two, range 2..32768.
REQ-002 The block SHALL have parameter LATENCY, default 3, meaning the number of cycles from request acceptance to mem_resp, range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_read, input, 1 bit: read request, held high by the initiator until mem_resp.
REQ-006 The block SHALL have port mem_write, input, 1 bit: write request, held high by the initiator until mem_resp.
REQ-007 The block SHALL have port mem_byte_enable, input, 2 bits: write byte mask; bit0 = low byte [7:0], bit1 = high byte [15:8].
REQ-008 The block SHALL have port mem_address, input, 16 bits: byte address.
REQ-009 The block SHALL have port mem_wdata, input, 16 bits: write data.
REQ-010 The block SHALL have port mem_rdata, output, 16 bits: read data.
REQ-011 The block SHALL have port mem_resp, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The block SHALL implement an FSM with three states: IDLE, BUSY and RESP.
REQ-013 IDLE SHALL accept a request on any posedge where mem_read or mem_write is high, then:
- capture word index mem_address[log2(DEPTH_WORDS):1], ignoring bit 0 and all higher bits (aliasing);
- capture mem_wdata, mem_byte_enable and the op;
- load the down-counter with LATENCY-1;
- go to BUSY, or to RESP if LATENCY=1.
REQ-014 When mem_read and mem_write are high together, the request SHALL be treated as a write only, and mem_rdata SHALL be left unchanged.
REQ-015 BUSY SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 0.
REQ-016 mem_resp SHALL be high for exactly the one cycle the FSM is in RESP, so it is asserted LATENCY cycles after the accepting edge.
REQ-017 RESP SHALL return to IDLE unconditionally; a request still high in the cycle after RESP SHALL be accepted as a new request.
REQ-018 For a read, mem_rdata SHALL be loaded with the stored word so it is valid throughout the mem_resp cycle, and SHALL hold that value until the next read completes.
REQ-019 For a write, the array SHALL be updated on the edge that enters RESP, per byte: lanes with enable=0 are untouched; mask 2'b00 SHALL complete with mem_resp and no storage change.
REQ-020 Changes on mem_address, mem_wdata or mem_byte_enable after acceptance SHALL be ignored for the in-flight request.
REQ-021 Abort: if the captured request's strobe (mem_read, or mem_write for writes) is low during BUSY, the FSM SHALL return to IDLE with no write, no mem_resp and mem_rdata unchanged.
REQ-022 A request completion and a new request SHALL never overlap; at most one request is in flight.
REQ-023 A read that follows a write to the same word SHALL return the written data (read-after-write coherence).

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, counter=0, mem_resp=0 and mem_rdata=16'h0000, including mid-request.
REQ-025 An in-flight write aborted by reset before entering RESP SHALL NOT modify the array.
REQ-026 Array contents SHALL NOT be reset; contents are undefined until written.
REQ-027 The first acceptance SHALL be possible on the first posedge after rst_n deasserts.

Verification
REQ-028 Word write then read: LATENCY=3, write addr 16'h0010, data 16'hBEEF, mask 2'b11 -> mem_resp 3 cycles after acceptance; a later read of 16'h0010 -> mem_rdata=16'hBEEF in its mem_resp cycle.
REQ-029 Byte masking: word 16'h1234 at 16'h0020; write 16'hABCD with mask 2'b01 -> read 16'h12CD; then write mask 2'b10 with 16'h5600 -> read 16'h56CD.
REQ-030 Address aliasing and odd byte address, DEPTH_WORDS=256:
- write 16'h0042 with 16'h7777 -> reading 16'h0043 returns 16'h7777;
- reading 16'h0242 returns 16'h7777.
REQ-031 Simultaneous read and write plus LATENCY=1: both strobes high -> treated as write, mem_resp on the next cycle, mem_rdata unchanged.
REQ-032 Abort and reset:
- mem_write dropped in BUSY -> no mem_resp, word unchanged;
- rst_n pulsed low mid-BUSY -> mem_resp=0 and mem_rdata=0 immediately, word unchanged.
REQ-033 LC-3b-style back-to-back accesses: read held until mem_resp, deasserted for one cycle, then write -> each access gets exactly one mem_resp pulse and data are correct.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// LC-3b style memory responder: one request in flight, a fixed response
// latency counted by a down-counter, byte-masked writes and read data held
// until the next completed read.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request in flight; accept a read or write on any edge
// BUSY  | request captured; counting down to the response edge
// RESP  | one-cycle mem_resp pulse; unconditionally back to IDLE
module lc3b_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [15:0]   wdata_q;
  logic [1:0]    be_q;
  logic          is_wr_q;

  logic [15:0]   mem [DEPTH_WORDS];

  // Word index drops the byte bit; upper address bits alias.
  logic [AW-1:0] addr_idx;
  assign addr_idx = AW'(mem_address >> 1);

  logic accept;
  logic strobe_ok;
  logic enter_resp;
  assign accept     = (state == IDLE) && (mem_read || mem_write);
  assign strobe_ok  = is_wr_q ? mem_write : mem_read;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // With LATENCY=1 the response is entered on the accepting edge, so the
  // live request fields are used instead of the not-yet-captured copies.
  logic [AW-1:0] idx_sel;
  logic [15:0]   wd_sel;
  logic [1:0]    be_sel;
  logic          wr_sel;
  assign idx_sel = (state == IDLE) ? addr_idx        : idx_q;
  assign wd_sel  = (state == IDLE) ? mem_wdata       : wdata_q;
  assign be_sel  = (state == IDLE) ? mem_byte_enable : be_q;
  assign wr_sel  = (state == IDLE) ? mem_write       : is_wr_q;

  logic mem_we;
  assign mem_we = enter_resp && wr_sel && rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a dropped strobe in BUSY aborts the request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY: begin
        if (!strobe_ok)       state_nxt = IDLE;
        else if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    mem_resp = (state == RESP);
  end

  // Request capture, latency counter and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 16'h0000;
      be_q      <= 2'b00;
      is_wr_q   <= 1'b0;
      mem_rdata <= 16'h0000;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        idx_q   <= addr_idx;
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        is_wr_q <= mem_write;
      end else if (state == BUSY) begin
        cnt <= strobe_ok ? cnt - 4'd1 : 4'd0;
      end
      if (enter_resp && !wr_sel) mem_rdata <= mem[idx_sel];
    end
  end

  // Storage array, byte-lane writes on the edge entering RESP; not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (be_sel[0]) mem[idx_sel][7:0]  <= wd_sel[7:0];
      if (be_sel[1]) mem[idx_sel][15:8] <= wd_sel[15:8];
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench for lc3b_mem_responder: instance 0 uses LATENCY=3,
// instance 1 uses LATENCY=1. Inputs are driven and outputs sampled on
// the falling edge.
module tb_lc3b_mem_responder;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [1:0]  be [2];
  logic [15:0] addr [2];
  logic [15:0] wd [2];
  logic [15:0] rdata [2];
  logic        resp [2];

  always #5 clk = ~clk;

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wd[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0])
  );

  lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wd[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mdl [2][256];
  logic [15:0] lrd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Must be called at a falling edge; returns at the falling edge after
  // the response, so back-to-back calls leave the strobes low one cycle.
  task automatic access(input int s, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] m, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    e.lat = (s == 1) ? LAT1 : LAT0;
    if (w) begin
      e.rdata = lrd[s];
      if (m[0]) mdl[s][a[8:1]][7:0]  = d[7:0];
      if (m[1]) mdl[s][a[8:1]][15:8] = d[15:8];
    end else begin
      e.rdata = mdl[s][a[8:1]];
      lrd[s]  = e.rdata;
    end
    sb.push_back(e);
    rd[s] = r; wr[s] = w; addr[s] = a; wd[s] = d; be[s] = m;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        addr[s] = ~a; wd[s] = ~d; be[s] = ~m;
      end
    end while (!resp[s] && cyc < 20);
    rd[s] = 1'b0; wr[s] = 1'b0;
    got = sb.pop_front();
    check({tag, " latency"}, cyc, got.lat);
    check({tag, " rdata"}, rdata[s], got.rdata);
    @(negedge clk);
    check({tag, " single pulse"}, resp[s], 1'b0);
  endtask

  initial begin
    int cyc;
    int n_resp;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 0; wr[s] = 0; be[s] = 0; addr[s] = 0; wd[s] = 0; lrd[s] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    check("reset resp0", resp[0], 1'b0);
    check("reset rdata0", rdata[0], 16'h0000);
    check("reset resp1", resp[1], 1'b0);
    check("reset rdata1", rdata[1], 16'h0000);
    rst_n = 1'b1;

    // Word write then read, first access right after reset release.
    access(0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, "wr beef");
    access(0, 1, 0, 16'h0010, 16'h0000, 2'b00, "rd beef");

    // Byte masking.
    access(0, 0, 1, 16'h0020, 16'h1234, 2'b11, "wr 1234");
    access(0, 0, 1, 16'h0020, 16'hABCD, 2'b01, "wr lo");
    access(0, 1, 0, 16'h0020, 16'h0000, 2'b00, "rd 12cd");
    access(0, 0, 1, 16'h0020, 16'h5600, 2'b10, "wr hi");
    access(0, 1, 0, 16'h0020, 16'h0000, 2'b00, "rd 56cd");

    // Odd byte address and aliasing, then an empty mask.
    access(0, 0, 1, 16'h0042, 16'h7777, 2'b11, "wr 7777");
    access(0, 1, 0, 16'h0043, 16'h0000, 2'b00, "rd odd");
    access(0, 1, 0, 16'h0242, 16'h0000, 2'b00, "rd alias");
    access(0, 0, 1, 16'h0042, 16'hFFFF, 2'b00, "wr mask00");
    access(0, 1, 0, 16'h0042, 16'h0000, 2'b00, "rd mask00");

    // Read held through its response is accepted again from IDLE.
    rd[0] = 1'b1; addr[0] = 16'h0010;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!resp[0] && cyc < 20);
    check("held first latency", cyc, LAT0);
    check("held first rdata", rdata[0], mdl[0][8'h08]);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!resp[0] && cyc < 20);
    check("held second latency", cyc, LAT0 + 1);
    check("held second rdata", rdata[0], mdl[0][8'h08]);
    rd[0] = 1'b0;
    lrd[0] = mdl[0][8'h08];
    @(negedge clk);
    check("held pulse end", resp[0], 1'b0);

    // Abort: write strobe dropped in BUSY.
    access(0, 0, 1, 16'h0050, 16'h1357, 2'b11, "wr 1357");
    access(0, 1, 0, 16'h0050, 16'h0000, 2'b00, "rd 1357");
    wr[0] = 1'b1; addr[0] = 16'h0050; wd[0] = 16'hEEEE; be[0] = 2'b11;
    @(negedge clk);
    wr[0] = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp[0]) n_resp++;
    end
    check("abort no resp", n_resp, 0);
    check("abort rdata held", rdata[0], 16'h1357);
    access(0, 1, 0, 16'h0050, 16'h0000, 2'b00, "rd after abort");

    // Reset mid-BUSY.
    wr[0] = 1'b1; addr[0] = 16'h0050; wd[0] = 16'h2468; be[0] = 2'b11;
    @(negedge clk);
    #2 rst_n = 1'b0;
    wr[0] = 1'b0;
    #1;
    check("midreset resp", resp[0], 1'b0);
    check("midreset rdata", rdata[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    lrd[0] = 16'h0000;
    lrd[1] = 16'h0000;
    access(0, 1, 0, 16'h0050, 16'h0000, 2'b00, "rd after reset");

    // LATENCY=1 instance with simultaneous strobes.
    access(1, 0, 1, 16'h0004, 16'hA5A5, 2'b11, "l1 wr a5a5");
    access(1, 1, 0, 16'h0004, 16'h0000, 2'b00, "l1 rd a5a5");
    access(1, 1, 1, 16'h0004, 16'h3C3C, 2'b11, "l1 both");
    access(1, 1, 0, 16'h0004, 16'h0000, 2'b00, "l1 rd 3c3c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
